// File: rtl/truth_table_pkg.sv
// Shared definitions for the truth-table sweep checker.
package truth_table_pkg;

  // Sweep controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Width of the per-vector settle counter; supports SETTLE up to 255.
  localparam int unsigned CNT_W = 8;

endpackage : truth_table_pkg

// File: rtl/truth_table_checker_settle_counter.sv
// Per-vector settle counter: counts clocks a stimulus vector has been held
// and flags the last clock before the response is sampled.
module settle_counter
  import truth_table_pkg::*;
#(
  parameter int unsigned SETTLE = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority over enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CNT_W'(SETTLE - 1));

endmodule : settle_counter

// File: rtl/truth_table_checker.sv
// Exhaustive truth-table sweep: drives every input vector to a DUT, holds
// it for SETTLE clocks, compares the response with a golden table and
// reports error count, first failing vector and pass/fail.
module truth_table_checker
  import truth_table_pkg::*;
#(
  parameter int unsigned          N_IN     = 3,
  parameter int unsigned          SETTLE   = 10,
  parameter logic [2**N_IN-1:0]   EXPECTED = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail,
  output logic            fail_valid
);

  state_e          state_q, state_d;
  logic [N_IN-1:0] dut_in_q, dut_in_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic            fv_q, fv_d;
  logic            pass_q, pass_d;
  logic            cnt_clr, cnt_en, cnt_tc;

  settle_counter #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  // Next-state, stimulus and result bookkeeping; abort outranks start.
  always_comb begin
    state_d  = state_q;
    dut_in_d = dut_in_q;
    err_d    = err_q;
    ff_d     = ff_q;
    fv_d     = fv_q;
    cnt_clr  = 1'b1;
    cnt_en   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (abort) begin
          state_d  = IDLE;
          dut_in_d = '0;
        end else if (start) begin
          state_d  = APPLY;
          dut_in_d = '0;
          err_d    = '0;
          ff_d     = '0;
          fv_d     = 1'b0;
        end
      end
      APPLY: begin
        if (abort) begin
          state_d  = IDLE;
          dut_in_d = '0;
        end else if (cnt_tc) begin
          if (dut_out != EXPECTED[dut_in_q]) begin
            if (err_q != '1) begin
              err_d = err_q + (N_IN+1)'(1);
            end
            if (!fv_q) begin
              ff_d = dut_in_q;
              fv_d = 1'b1;
            end
          end
          if (dut_in_q == '1) begin
            state_d = DONE;
          end else begin
            dut_in_d = dut_in_q + N_IN'(1);
          end
        end else begin
          cnt_clr = 1'b0;
          cnt_en  = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        dut_in_d = '0;
      end
    endcase
    // Derived from next-state values so pass is valid on the DONE entry edge.
    pass_d = (state_d == DONE) && (err_d == '0);
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dut_in_q <= '0;
      err_q    <= '0;
      ff_q     <= '0;
      fv_q     <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dut_in_q <= dut_in_d;
      err_q    <= err_d;
      ff_q     <= ff_d;
      fv_q     <= fv_d;
      pass_q   <= pass_d;
    end
  end

  assign dut_in     = dut_in_q;
  assign busy       = (state_q == APPLY);
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;
  assign fail_valid = fv_q;

endmodule : truth_table_checker

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: a 3-input majority configuration
// (SETTLE=10) and a 2-input AND configuration (SETTLE=1).
module tb_truth_table_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  // Instance A: N_IN=3, SETTLE=10, EXPECTED=8'hE8 (majority)
  logic       start_a = 1'b0, abort_a = 1'b0;
  logic [2:0] dut_in_a;
  logic       dut_out_a;
  logic       busy_a, done_a, pass_a, fv_a;
  logic [3:0] err_a;
  logic [2:0] ff_a;
  logic       stuck_a = 1'b0;

  // Instance B: N_IN=2, SETTLE=1, EXPECTED=4'h8 (AND)
  logic       start_b = 1'b0, abort_b = 1'b0;
  logic [1:0] dut_in_b;
  logic       dut_out_b;
  logic       busy_b, done_b, pass_b, fv_b;
  logic [2:0] err_b;
  logic [1:0] ff_b;
  logic       or_b = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int early_pass = 0;

  always #5 clk = ~clk;

  assign dut_out_a = stuck_a ? 1'b0 :
                     ((dut_in_a[0] & dut_in_a[1]) | (dut_in_a[0] & dut_in_a[2]) |
                      (dut_in_a[1] & dut_in_a[2]));
  assign dut_out_b = or_b ? (|dut_in_b) : (&dut_in_b);

  truth_table_checker #(
    .N_IN     (3),
    .SETTLE   (10),
    .EXPECTED (8'hE8)
  ) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_a),
    .abort      (abort_a),
    .dut_in     (dut_in_a),
    .dut_out    (dut_out_a),
    .busy       (busy_a),
    .done       (done_a),
    .pass       (pass_a),
    .err_count  (err_a),
    .first_fail (ff_a),
    .fail_valid (fv_a)
  );

  truth_table_checker #(
    .N_IN     (2),
    .SETTLE   (1),
    .EXPECTED (4'h8)
  ) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_b),
    .abort      (abort_b),
    .dut_in     (dut_in_b),
    .dut_out    (dut_out_b),
    .busy       (busy_b),
    .done       (done_b),
    .pass       (pass_b),
    .err_count  (err_b),
    .first_fail (ff_b),
    .fail_valid (fv_b)
  );

  // Launch a sweep on A from a negedge; optionally pulse start at clock
  // pulse_at of the sweep. Returns clocks from start edge to done (bounded).
  task automatic run_sweep(input int pulse_at, output int cycles);
    start_a = 1'b1;
    @(negedge clk);
    cycles = 0;
    while (cycles < 200) begin
      start_a = (cycles == pulse_at);
      @(negedge clk);
      cycles++;
      if (pass_a && !done_a) early_pass++;
      if (done_a) break;
    end
    start_a = 1'b0;
  endtask

  // Wait (bounded) until A is driving vector v.
  task automatic wait_vec(input logic [2:0] v);
    int n = 0;
    while (dut_in_a !== v && n < 200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (dut_in_a !== v) begin
      miscompares++;
      $display("FAIL wait_vec: dut_in=%0d required=%0d (timeout)", dut_in_a, v);
    end
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({busy_a, done_a, pass_a, fv_a, err_a, ff_a, dut_in_a} !== '0) begin
      miscompares++;
      $display("FAIL reset_a: outputs=%h required=0", {busy_a, done_a, pass_a, fv_a, err_a, ff_a, dut_in_a});
    end
    vectors++;
    if ({busy_b, done_b, pass_b, fv_b, err_b, ff_b, dut_in_b} !== '0) begin
      miscompares++;
      $display("FAIL reset_b: outputs=%h required=0", {busy_b, done_b, pass_b, fv_b, err_b, ff_b, dut_in_b});
    end
    // Start presented together with reset release must be taken on the first edge.
    @(negedge clk);
    rst_n = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    vectors++;
    if (busy_a !== 1'b1) begin
      miscompares++;
      $display("FAIL first_start: busy=%b required=1", busy_a);
    end
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    vectors++;
    if (busy_a !== 1'b0) begin
      miscompares++;
      $display("FAIL first_start_abort: busy=%b required=0", busy_a);
    end
  endtask

  task automatic test_majority_pass();
    int cyc;
    stuck_a = 1'b0;
    run_sweep(-1, cyc);
    vectors++;
    if (cyc != 80) begin miscompares++; $display("FAIL maj_latency: clocks=%0d required=80", cyc); end
    vectors++;
    if (pass_a !== 1'b1) begin miscompares++; $display("FAIL maj_pass: pass=%b required=1", pass_a); end
    vectors++;
    if (err_a !== 4'd0) begin miscompares++; $display("FAIL maj_err: err=%0d required=0", err_a); end
    vectors++;
    if (fv_a !== 1'b0) begin miscompares++; $display("FAIL maj_fv: fail_valid=%b required=0", fv_a); end
    vectors++;
    if (busy_a !== 1'b0) begin miscompares++; $display("FAIL maj_busy: busy=%b required=0", busy_a); end
    @(negedge clk);
    vectors++;
    if ({done_a, pass_a} !== 2'b11) begin
      miscompares++;
      $display("FAIL maj_hold: done,pass=%b required=11", {done_a, pass_a});
    end
  endtask

  task automatic test_stuck_zero();
    int cyc;
    stuck_a = 1'b1;
    run_sweep(-1, cyc);
    stuck_a = 1'b0;
    vectors++;
    if (cyc != 80) begin miscompares++; $display("FAIL stuck_latency: clocks=%0d required=80", cyc); end
    vectors++;
    if (err_a !== 4'd4) begin miscompares++; $display("FAIL stuck_err: err=%0d required=4", err_a); end
    vectors++;
    if (ff_a !== 3'd3) begin miscompares++; $display("FAIL stuck_first: first_fail=%0d required=3", ff_a); end
    vectors++;
    if (fv_a !== 1'b1) begin miscompares++; $display("FAIL stuck_fv: fail_valid=%b required=1", fv_a); end
    vectors++;
    if (pass_a !== 1'b0) begin miscompares++; $display("FAIL stuck_pass: pass=%b required=0", pass_a); end
  endtask

  task automatic test_start_ignored();
    int cyc;
    run_sweep(30, cyc);
    vectors++;
    if (cyc != 80) begin miscompares++; $display("FAIL start_ignored: clocks=%0d required=80", cyc); end
    vectors++;
    if (pass_a !== 1'b1) begin miscompares++; $display("FAIL start_ignored_pass: pass=%b required=1", pass_a); end
  endtask

  task automatic test_abort();
    int cyc;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_vec(3'd5);
    abort_a = 1'b1;
    start_a = 1'b1;   // abort must win over a simultaneous start
    @(negedge clk);
    abort_a = 1'b0;
    start_a = 1'b0;
    vectors++;
    if ({busy_a, done_a, dut_in_a} !== 5'b0) begin
      miscompares++;
      $display("FAIL abort_state: busy,done,dut_in=%b required=00000", {busy_a, done_a, dut_in_a});
    end
    run_sweep(-1, cyc);
    vectors++;
    if (cyc != 80) begin miscompares++; $display("FAIL abort_rerun: clocks=%0d required=80", cyc); end
    vectors++;
    if (pass_a !== 1'b1) begin miscompares++; $display("FAIL abort_rerun_pass: pass=%b required=1", pass_a); end
  endtask

  task automatic test_abort_retains();
    stuck_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_vec(3'd5);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    stuck_a = 1'b0;
    vectors++;
    if ({err_a, ff_a, fv_a} !== {4'd1, 3'd3, 1'b1}) begin
      miscompares++;
      $display("FAIL abort_retain: err=%0d first=%0d fv=%b required err=1 first=3 fv=1", err_a, ff_a, fv_a);
    end
    vectors++;
    if ({done_a, pass_a, busy_a} !== 3'b000) begin
      miscompares++;
      $display("FAIL abort_retain_flags: done,pass,busy=%b required=000", {done_a, pass_a, busy_a});
    end
  endtask

  task automatic test_async_reset();
    stuck_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_vec(3'd2);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy_a, done_a, pass_a, fv_a, err_a, ff_a, dut_in_a} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: outputs=%h required=0", {busy_a, done_a, pass_a, fv_a, err_a, ff_a, dut_in_a});
    end
    @(negedge clk);
    rst_n = 1'b1;
    stuck_a = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy_a, dut_in_a} !== 4'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: busy,dut_in=%b required=0000", {busy_a, dut_in_a});
    end
  endtask

  task automatic test_settle_one();
    logic [1:0] exp_in [3];
    exp_in[0] = 2'd1; exp_in[1] = 2'd2; exp_in[2] = 2'd3;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    vectors++;
    if ({busy_b, dut_in_b} !== 3'b100) begin
      miscompares++;
      $display("FAIL s1_start: busy,dut_in=%b required=100", {busy_b, dut_in_b});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (dut_in_b !== exp_in[i]) begin
        miscompares++;
        $display("FAIL s1_step%0d: dut_in=%0d required=%0d", i, dut_in_b, exp_in[i]);
      end
    end
    @(negedge clk);
    vectors++;
    if ({done_b, pass_b, busy_b} !== 3'b110) begin
      miscompares++;
      $display("FAIL s1_done: done,pass,busy=%b required=110", {done_b, pass_b, busy_b});
    end
    // Start held high in DONE relaunches on the next edge.
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    vectors++;
    if ({busy_b, done_b, pass_b, dut_in_b} !== 5'b10000) begin
      miscompares++;
      $display("FAIL s1_restart: busy,done,pass,dut_in=%b required=10000", {busy_b, done_b, pass_b, dut_in_b});
    end
    or_b = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if ({done_b, pass_b, err_b, ff_b, fv_b} !== {1'b1, 1'b0, 3'd2, 2'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL s1_or: done=%b pass=%b err=%0d first=%0d fv=%b required done=1 pass=0 err=2 first=1 fv=1",
               done_b, pass_b, err_b, ff_b, fv_b);
    end
    or_b = 1'b0;
    abort_b = 1'b1;
    @(negedge clk);
    abort_b = 1'b0;
    vectors++;
    if ({done_b, busy_b} !== 2'b00) begin
      miscompares++;
      $display("FAIL done_abort: done,busy=%b required=00", {done_b, busy_b});
    end
  endtask

  initial begin
    test_reset();
    test_majority_pass();
    test_stuck_zero();
    test_start_ignored();
    test_abort();
    test_abort_retains();
    test_async_reset();
    test_settle_one();
    vectors++;
    if (early_pass != 0) begin
      miscompares++;
      $display("FAIL pass_early: pass-without-done samples=%0d required=0", early_pass);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_truth_table_checker
